mips_decode_pipe: RTL and testbench
===================================

MIPS_DECODE_PIPE -- requirements
Module: mips_decode_pipe

Interface
REQ-001 SHALL provide parameter: CNT_W, default 8, width of the exception counter (range 1..16).
REQ-002 SHALL provide ports, one per line:
- clock  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  decoder can accept an instruction this cycle.
- inst  in  32  MIPS instruction word.
- out_valid  out  1  decoded entry presented.
- out_ready  in  1  consumer takes the entry this cycle.
- alu_op  out  3  ALU control.
- rd_src  out  1  destination select: 0 = rd, 1 = rt.
- alu_src2  out  1  2nd ALU operand select: 0 = register, 1 = immediate.
- writeenable  out  1  register-file write enable.
- except  out  1  unrecognised opcode/funct.
- rs  out  5  inst[25:21].
- wr_reg  out  5  destination register number (rd or rt per rd_src; 0 when except).
- imm32  out  32  extended immediate.
- exc_count  out  CNT_W  exception counter (only when EXC_COUNT_EN is defined).
- exc_clr  in  1  synchronous counter clear (only when EXC_COUNT_EN is defined).

Function
REQ-003 SHALL decode opcode = inst[31:26] and funct = inst[5:0] using these values:
- R-type opcode 6'h00 with funct add 6'h20, sub 6'h22, and 6'h24, or 6'h25, xor 6'h26, nor 6'h27.
- I-type opcodes addi 6'h08, andi 6'h0c, ori 6'h0d, xori 6'h0e.
REQ-004 SHALL set alu_op to add 010, sub 011, and 100, or 101, nor 110, xor 111; addi/andi/ori/xori SHALL map to 010/100/101/111 respectively.
REQ-005 SHALL drive rd_src=0 and alu_src2=0 for R-type instructions, and 1/1 for I-type instructions.
REQ-006 SHALL drive imm32 as the sign-extended inst[15:0] for addi, the zero-extended inst[15:0] for andi/ori/xori, and 0 for R-type and exceptions.
REQ-007 SHALL treat any other opcode/funct combination as an exception: except=1, writeenable=0, alu_op=000, rd_src=0, alu_src2=0, wr_reg=0, imm32=0; the entry SHALL still pass through the buffer.
REQ-008 SHALL decode at acceptance time and store the result in a 2-entry FIFO (head and skid); inst SHALL NOT be stored raw.
REQ-009 SHALL assert in_ready exactly when occupancy < 2, driven from registered state only, with no combinational path from out_ready.
REQ-010 SHALL push on in_valid&&in_ready and pop on out_valid&&out_ready; out_valid = (occupancy != 0).
REQ-011 Latency: an instruction accepted at edge N into an empty buffer SHALL appear on the outputs after edge N, i.e. 1 cycle.
REQ-012 Simultaneous push and pop at occupancy 1: occupancy SHALL stay 1 and the new entry SHALL become the head.
REQ-013 At occupancy 2, the pop SHALL promote skid to head; a push in the same cycle is impossible because in_ready=0.
REQ-014 Order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-015 While out_valid=0, all decoded outputs SHALL read 0.
REQ-016 A head entry held with out_ready=0 SHALL remain stable on the outputs.

Reset
REQ-017 reset low SHALL immediately clear occupancy to 0, so out_valid=0, in_ready=1 and all decoded outputs are 0; exc_count SHALL be 0 when present.
REQ-018 Reset asserted mid-transfer SHALL discard buffered entries; there is no recovery of in-flight instructions.

Configuration
REQ-019 Macro EXC_COUNT_EN defined: exc_count and exc_clr ports SHALL exist. exc_count SHALL increment by 1 on each accepted except instruction and saturate at 2^CNT_W-1. With exc_clr=1 it SHALL load 1 if an except instruction is accepted in that cycle, else 0.
REQ-020 Macro EXC_COUNT_EN undefined: the ports and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Empty buffer, push add $3,$1,$2 (32'h00221820), out_ready=1 -> next cycle out_valid=1, alu_op=010, wr_reg=3, writeenable=1, except=0.
REQ-022 Push addi $5,$0,-1 (32'h2005FFFF) -> imm32=32'hFFFFFFFF, rd_src=1, alu_src2=1, wr_reg=5; push andi $5,$0,16'hFFFF (32'h3005FFFF) -> imm32=32'h0000FFFF.
REQ-023 out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepted; raising out_ready drains the 2 entries in order; the 3rd is accepted only after in_ready returns to 1.
REQ-024 Push opcode 6'h3F -> except=1, writeenable=0, alu_op=000; with EXC_COUNT_EN and CNT_W=2, 5 such pushes -> exc_count=3 (saturated).
REQ-025 Occupancy 1, simultaneous push and pop -> occupancy stays 1 and the new entry is on the outputs next cycle; reset asserted with occupancy 2 -> out_valid=0 and in_ready=1 immediately, without a clock edge.

Source files
------------

// File: rtl/mips_decode_pipe.sv
// mips_decode_pipe: decodes a subset of MIPS R-type and I-type ALU
// instructions when they are accepted, and holds the decoded result in a
// two-entry buffer (head plus skid) behind a valid/ready handshake.
// Optional feature macro: EXC_COUNT_EN adds a saturating counter of accepted
// exception instructions, together with its exc_count/exc_clr ports.
module mips_decode_pipe #(
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_op,
    output logic              rd_src,
    output logic              alu_src2,
    output logic              writeenable,
    output logic              except,
    output logic [4:0]        rs,
    output logic [4:0]        wr_reg,
    output logic [31:0]       imm32
`ifdef EXC_COUNT_EN
    ,
    output logic [CNT_W-1:0]  exc_count,
    input  logic              exc_clr
`endif
);

    // One decoded buffer entry. The raw instruction is never stored.
    typedef struct packed {
        logic [2:0]  alu_op;
        logic        rd_src;
        logic        alu_src2;
        logic        writeenable;
        logic        except;
        logic [4:0]  rs;
        logic [4:0]  wr_reg;
        logic [31:0] imm32;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0};

    // Turns an instruction word into a decoded entry; anything not in the
    // supported subset becomes an exception entry with every control field
    // cleared, so it can never write the register file.
    function automatic entry_t decode(input logic [31:0] word);
        entry_t e;
        logic   valid_op;
        e          = ENTRY_ZERO;
        valid_op   = 1'b1;
        e.rs       = word[25:21];
        case (word[31:26])
            6'h00: begin
                e.rd_src   = 1'b0;
                e.alu_src2 = 1'b0;
                case (word[5:0])
                    6'h20:   e.alu_op = 3'b010;
                    6'h22:   e.alu_op = 3'b011;
                    6'h24:   e.alu_op = 3'b100;
                    6'h25:   e.alu_op = 3'b101;
                    6'h26:   e.alu_op = 3'b111;
                    6'h27:   e.alu_op = 3'b110;
                    default: valid_op = 1'b0;
                endcase
            end
            6'h08: begin
                e.alu_op   = 3'b010;
                e.rd_src   = 1'b1;
                e.alu_src2 = 1'b1;
                e.imm32    = {{16{word[15]}}, word[15:0]};
            end
            6'h0c: begin
                e.alu_op   = 3'b100;
                e.rd_src   = 1'b1;
                e.alu_src2 = 1'b1;
                e.imm32    = {16'h0000, word[15:0]};
            end
            6'h0d: begin
                e.alu_op   = 3'b101;
                e.rd_src   = 1'b1;
                e.alu_src2 = 1'b1;
                e.imm32    = {16'h0000, word[15:0]};
            end
            6'h0e: begin
                e.alu_op   = 3'b111;
                e.rd_src   = 1'b1;
                e.alu_src2 = 1'b1;
                e.imm32    = {16'h0000, word[15:0]};
            end
            default: valid_op = 1'b0;
        endcase
        if (valid_op) begin
            e.writeenable = 1'b1;
            e.except      = 1'b0;
            e.wr_reg      = e.rd_src ? word[20:16] : word[15:11];
        end else begin
            e          = ENTRY_ZERO;
            e.rs       = word[25:21];
            e.except   = 1'b1;
        end
        return e;
    endfunction

    logic [1:0] occ_r;
    entry_t     head_r;
    entry_t     skid_r;
    entry_t     dec_s;
    logic       push_s;
    logic       pop_s;

    // in_ready depends only on the occupancy register (occupancy is 0..2,
    // so bit 1 set means full); out_valid likewise.
    assign in_ready  = ~occ_r[1];
    assign out_valid = (occ_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign dec_s     = decode(inst);

    // Buffer update: the head register is forced to zero whenever the buffer
    // empties, so the outputs read 0 while out_valid is low with no gating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_r  <= 2'd0;
            head_r <= ENTRY_ZERO;
            skid_r <= ENTRY_ZERO;
        end else begin
            case (occ_r)
                2'd0: begin
                    if (push_s) begin
                        head_r <= dec_s;
                        occ_r  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_r <= dec_s;
                    end else if (push_s) begin
                        skid_r <= dec_s;
                        occ_r  <= 2'd2;
                    end else if (pop_s) begin
                        head_r <= ENTRY_ZERO;
                        occ_r  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_r <= skid_r;
                        skid_r <= ENTRY_ZERO;
                        occ_r  <= 2'd1;
                    end
                end
                default: begin
                    occ_r  <= 2'd0;
                    head_r <= ENTRY_ZERO;
                    skid_r <= ENTRY_ZERO;
                end
            endcase
        end
    end

    assign alu_op      = head_r.alu_op;
    assign rd_src      = head_r.rd_src;
    assign alu_src2    = head_r.alu_src2;
    assign writeenable = head_r.writeenable;
    assign except      = head_r.except;
    assign rs          = head_r.rs;
    assign wr_reg      = head_r.wr_reg;
    assign imm32       = head_r.imm32;

`ifdef EXC_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] exc_cnt_r;
    logic             exc_hit_s;

    assign exc_hit_s = push_s && dec_s.except;

    // Saturating count of accepted exception instructions; a clear in the
    // same cycle as an accepted exception still records that one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_cnt_r <= {CNT_W{1'b0}};
        end else if (exc_clr) begin
            exc_cnt_r <= exc_hit_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (exc_hit_s && (exc_cnt_r != CNT_MAX)) begin
            exc_cnt_r <= exc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            exc_cnt_r <= exc_cnt_r;
        end
    end

    assign exc_count = exc_cnt_r;
`endif

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed self-checking bench for mips_decode_pipe (CNT_W = 2 so the
// exception counter saturates quickly when EXC_COUNT_EN is defined).
module tb_mips_decode_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic        rd_src;
    logic        alu_src2;
    logic        writeenable;
    logic        except;
    logic [4:0]  rs;
    logic [4:0]  wr_reg;
    logic [31:0] imm32;
`ifdef EXC_COUNT_EN
    logic [1:0]  exc_count;
    logic        exc_clr;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    mips_decode_pipe #(.CNT_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst        (inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .rd_src      (rd_src),
        .alu_src2    (alu_src2),
        .writeenable (writeenable),
        .except      (except),
        .rs          (rs),
        .wr_reg      (wr_reg),
        .imm32       (imm32)
`ifdef EXC_COUNT_EN
        ,
        .exc_count   (exc_count),
        .exc_clr     (exc_clr)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one instruction for exactly one edge, then withdraw it.
    task automatic offer(input logic [31:0] word);
        in_valid = 1'b1;
        inst     = word;
        tick();
        in_valid = 1'b0;
        inst     = 32'h0000_0000;
    endtask

    // Check the full decoded head entry.
    task automatic chk_entry(input string tag, input logic [2:0] op, input logic rsrc,
                             input logic src2, input logic we, input logic ex,
                             input logic [4:0] wreg, input logic [31:0] imm);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".alu_op"}, {29'd0, alu_op}, {29'd0, op});
        chk({tag, ".rd_src"}, {31'd0, rd_src}, {31'd0, rsrc});
        chk({tag, ".alu_src2"}, {31'd0, alu_src2}, {31'd0, src2});
        chk({tag, ".we"}, {31'd0, writeenable}, {31'd0, we});
        chk({tag, ".except"}, {31'd0, except}, {31'd0, ex});
        chk({tag, ".wr_reg"}, {27'd0, wr_reg}, {27'd0, wreg});
        chk({tag, ".imm32"}, imm32, imm);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".alu_op"}, {29'd0, alu_op}, 32'd0);
        chk({tag, ".we"}, {31'd0, writeenable}, 32'd0);
        chk({tag, ".wr_reg"}, {27'd0, wr_reg}, 32'd0);
        chk({tag, ".imm32"}, imm32, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        inst      = 32'h0000_0000;
        out_ready = 1'b1;
`ifdef EXC_COUNT_EN
        exc_clr   = 1'b0;
`endif
        #12;
        chk_empty("reset");
`ifdef EXC_COUNT_EN
        chk("reset.exc_count", {30'd0, exc_count}, 32'd0);
`endif
        reset = 1'b1;
        tick();

        // add $3,$1,$2 into empty buffer: visible one cycle later
        offer(32'h0022_1820);
        chk_entry("add", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0000);
        chk("add.rs", {27'd0, rs}, 32'd1);
        tick();
        chk_empty("add_drained");

        // addi $5,$0,-1 then andi in the same cycle as the addi pops
        offer(32'h2005_FFFF);
        chk_entry("addi", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFFF);
        offer(32'h3005_FFFF);
        chk_entry("andi_pp", 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_FFFF);
        chk("andi_pp.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_empty("andi_drained");

        // backpressure: sub, or, xor offered back-to-back with out_ready=0
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst      = 32'h0022_2022;
        tick();
        chk("bp1.in_ready", {31'd0, in_ready}, 32'd1);
        inst = 32'h0022_3025;
        tick();
        chk("bp2.in_ready", {31'd0, in_ready}, 32'd0);
        chk_entry("bp2.sub", 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0);
        inst = 32'h0022_3826;
        tick();
        chk("bp3.in_ready", {31'd0, in_ready}, 32'd0);
        chk_entry("bp3.sub_held", 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0);
        out_ready = 1'b1;
        tick();
        chk_entry("drain.or", 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0);
        chk("drain.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_entry("drain.xor", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0);
        in_valid = 1'b0;
        tick();
        chk_empty("drain_done");

        // remaining ALU forms
        offer(32'h0022_4027);
        chk_entry("nor", 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0);
        tick();
        offer(32'h0022_1824);
        chk_entry("and", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
        tick();
        offer(32'h3429_8001);
        chk_entry("ori", 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_8001);
        tick();
        offer(32'h382A_8000);
        chk_entry("xori", 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_8000);
        tick();
        offer(32'h2022_0005);
        chk_entry("addi_pos", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0005);
        tick();

        // exceptions: unknown opcode and unknown R-type funct
        offer(32'hFC22_1820);
        chk_entry("exc_op", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        tick();
        offer(32'h0022_1821);
        chk_entry("exc_funct", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        tick();
`ifdef EXC_COUNT_EN
        chk("cnt2", {30'd0, exc_count}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            offer(32'hFC00_0000);
            tick();
        end
        chk("cnt_sat", {30'd0, exc_count}, 32'd3);
        exc_clr = 1'b1;
        offer(32'hFC00_0000);
        exc_clr = 1'b0;
        chk("cnt_clr_hit", {30'd0, exc_count}, 32'd1);
        tick();
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        chk("cnt_clr", {30'd0, exc_count}, 32'd0);
`endif

        // reset with two entries buffered: clears without a clock edge
        out_ready = 1'b0;
        offer(32'h0022_1820);
        offer(32'h0022_2022);
        chk("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_empty("async_rst");
        #2;
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_empty("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
